// File: rtl/candy_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : candy_fetch_ctrl
// Description : Instruction fetch controller: single-buffered SRAM fetch with
//               decode handshake, flush, timeout abort and delivery counter.
// Revision    : 1.0 - initial release
// ============================================================================
module candy_fetch_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_enable,
  output logic              sram_ce,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic              sram_ready,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic              fetch_err,
  output logic [15:0]       fetch_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Abort fires on the last allowed FETCH cycle, so compare against TIMEOUT-1.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;

  assign sram_ce   = (state == FETCH);
  assign sram_addr = pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wait_cnt    <= 8'd0;
      pc_enable   <= 1'b0;
      inst_valid  <= 1'b0;
      inst        <= '0;
      inst_pc     <= '0;
      fetch_err   <= 1'b0;
      fetch_count <= 16'd0;
    end else begin
      pc_enable <= 1'b0;
      fetch_err <= 1'b0;
      case (state)
        IDLE: begin
          wait_cnt <= 8'd0;
          if (fetch_en && !stall && !flush) state <= FETCH;
        end
        FETCH: begin
          // Flush wins over a returning read and over the timeout.
          if (flush) begin
            wait_cnt <= 8'd0;
            state    <= IDLE;
          end else if (sram_ready) begin
            inst       <= sram_rdata;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
            pc_enable  <= 1'b1;
            wait_cnt   <= 8'd0;
            state      <= HOLD;
          end else if (wait_cnt == WAIT_LAST) begin
            fetch_err <= 1'b1;
            wait_cnt  <= 8'd0;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        HOLD: begin
          wait_cnt <= 8'd0;
          if (flush) begin
            inst_valid <= 1'b0;
            state      <= IDLE;
          end else if (inst_ready) begin
            inst_valid  <= 1'b0;
            fetch_count <= fetch_count + 16'd1;
            state       <= (fetch_en && !stall) ? FETCH : IDLE;
          end
        end
        default: begin
          wait_cnt   <= 8'd0;
          inst_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_candy_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_candy_fetch_ctrl
// Description : Directed self-checking bench for candy_fetch_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_candy_fetch_ctrl;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              fetch_en = 1'b0;
  logic              stall = 1'b0;
  logic              flush = 1'b0;
  logic [ADDR_W-1:0] pc = '0;
  logic              pc_enable;
  logic              sram_ce;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_ready = 1'b0;
  logic [DATA_W-1:0] sram_rdata = '0;
  logic              inst_valid;
  logic [DATA_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready = 1'b0;
  logic              fetch_err;
  logic [15:0]       fetch_count;

  int errors = 0;
  int checks = 0;

  candy_fetch_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .stall(stall), .flush(flush),
    .pc(pc), .pc_enable(pc_enable), .sram_ce(sram_ce), .sram_addr(sram_addr),
    .sram_ready(sram_ready), .sram_rdata(sram_rdata), .inst_valid(inst_valid),
    .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .fetch_err(fetch_err), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Outputs are sampled and inputs changed on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) tick();
    checks++;
    if ({pc_enable, sram_ce, inst_valid, fetch_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctl: got %b want 0000", {pc_enable, sram_ce, inst_valid, fetch_err});
    end
    checks++;
    if (fetch_count !== 16'd0 || inst !== '0 || inst_pc !== '0) begin
      errors++;
      $display("FAIL reset_data: count=%h inst=%h inst_pc=%h want 0", fetch_count, inst, inst_pc);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int pulses = 0;
    pc = 32'h0; inst_ready = 1'b1; fetch_en = 1'b1;
    tick();
    checks++;
    if (sram_ce !== 1'b1 || sram_addr !== 32'h0) begin
      errors++;
      $display("FAIL basic_ce: ce=%b addr=%h want 1/0", sram_ce, sram_addr);
    end
    tick();
    sram_ready = 1'b1; sram_rdata = 32'h12345678;
    tick();
    sram_ready = 1'b0; fetch_en = 1'b0;
    if (pc_enable) pulses++;
    checks++;
    if (inst_valid !== 1'b1 || inst !== 32'h12345678 || inst_pc !== 32'h0) begin
      errors++;
      $display("FAIL basic_cap: valid=%b inst=%h pc=%h want 1/12345678/0", inst_valid, inst, inst_pc);
    end
    tick();
    if (pc_enable) pulses++;
    checks++;
    if (pulses !== 1 || fetch_count !== 16'd1 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: pulses=%0d count=%0d valid=%b want 1/1/0", pulses, fetch_count, inst_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] c0 = fetch_count;
    int bad = 0;
    pc = 32'h40; inst_ready = 1'b0; fetch_en = 1'b1;
    tick();
    sram_ready = 1'b1; sram_rdata = 32'hCAFE0040;
    tick();
    sram_ready = 1'b0; fetch_en = 1'b0;
    checks++;
    if (pc_enable !== 1'b1 || inst_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_first: pc_enable=%b valid=%b want 1/1", pc_enable, inst_valid);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (inst_valid !== 1'b1 || inst !== 32'hCAFE0040 || inst_pc !== 32'h40 ||
          sram_ce !== 1'b0 || pc_enable !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d bad hold cycles, want 0", bad);
    end
    inst_ready = 1'b1;
    tick();
    checks++;
    if (inst_valid !== 1'b0 || fetch_count !== c0 + 16'd1) begin
      errors++;
      $display("FAIL bp_accept: valid=%b count=%0d want 0/%0d", inst_valid, fetch_count, c0 + 16'd1);
    end
  endtask

  task automatic test_timeout();
    logic [15:0] c0 = fetch_count;
    int ce_cycles = 0;
    int pe = 0;
    bit seen = 1'b0;
    sram_ready = 1'b0; inst_ready = 1'b0; fetch_en = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      fetch_en = 1'b0;
      if (pc_enable) pe++;
      if (fetch_err) seen = 1'b1;
      else if (sram_ce) ce_cycles++;
    end
    checks++;
    if (!seen || ce_cycles != TIMEOUT) begin
      errors++;
      $display("FAIL timeout_err: seen=%b fetch_cycles=%0d want 1/%0d", seen, ce_cycles, TIMEOUT);
    end
    checks++;
    if (sram_ce !== 1'b0 || pe != 0 || fetch_count !== c0) begin
      errors++;
      $display("FAIL timeout_state: ce=%b pc_en=%0d count=%0d want 0/0/%0d", sram_ce, pe, fetch_count, c0);
    end
    tick();
    checks++;
    if (fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: fetch_err=%b want 0", fetch_err);
    end
  endtask

  task automatic test_flush();
    logic [15:0] c0 = fetch_count;
    logic [DATA_W-1:0] old_inst = inst;
    fetch_en = 1'b1; pc = 32'h80;
    tick();
    fetch_en = 1'b0; sram_ready = 1'b1; sram_rdata = 32'hDEADBEEF; flush = 1'b1;
    tick();
    sram_ready = 1'b0; flush = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || pc_enable !== 1'b0 || sram_ce !== 1'b0 || inst !== old_inst) begin
      errors++;
      $display("FAIL flush_fetch: valid=%b pe=%b ce=%b inst=%h want 0/0/0/%h",
               inst_valid, pc_enable, sram_ce, inst, old_inst);
    end
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0; sram_ready = 1'b1; sram_rdata = 32'h0BADF00D;
    tick();
    sram_ready = 1'b0; inst_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; inst_ready = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || fetch_count !== c0 || sram_ce !== 1'b0) begin
      errors++;
      $display("FAIL flush_hold: valid=%b count=%0d ce=%b want 0/%0d/0", inst_valid, fetch_count, sram_ce, c0);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] c0 = fetch_count;
    int pulses = 0;
    int consec = 0;
    logic prev = 1'b0;
    fetch_en = 1'b1; sram_ready = 1'b1; inst_ready = 1'b1; sram_rdata = 32'h11110000;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (pc_enable) pulses++;
      if (pc_enable && prev) consec++;
      prev = pc_enable;
    end
    fetch_en = 1'b0; sram_ready = 1'b0;
    tick();
    inst_ready = 1'b0;
    checks++;
    if (pulses != 4 || consec != 0 || fetch_count !== c0 + 16'd4) begin
      errors++;
      $display("FAIL b2b: pulses=%0d consec=%0d count=%0d want 4/0/%0d", pulses, consec, fetch_count, c0 + 16'd4);
    end
  endtask

  task automatic test_stall_reset();
    int ce_seen = 0;
    stall = 1'b1; fetch_en = 1'b1;
    repeat (3) begin
      tick();
      if (sram_ce) ce_seen++;
    end
    checks++;
    if (ce_seen != 0) begin
      errors++;
      $display("FAIL stall_idle: ce cycles=%0d want 0", ce_seen);
    end
    stall = 1'b0;
    tick();
    fetch_en = 1'b0;
    checks++;
    if (sram_ce !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: ce=%b want 1", sram_ce);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({pc_enable, sram_ce, inst_valid, fetch_err} !== 4'b0000 || fetch_count !== 16'd0 ||
        inst !== '0 || inst_pc !== '0) begin
      errors++;
      $display("FAIL async_reset: ctl=%b count=%0d inst=%h inst_pc=%h want 0",
               {pc_enable, sram_ce, inst_valid, fetch_err}, fetch_count, inst, inst_pc);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_wrap();
    force dut.fetch_count = 16'hFFFF;
    #1;
    release dut.fetch_count;
    #1;
    checks++;
    if (fetch_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_preload: count=%h want ffff", fetch_count);
    end
    tick();
    fetch_en = 1'b1; pc = 32'hC0;
    tick();
    fetch_en = 1'b0; sram_ready = 1'b1; sram_rdata = 32'h55AA55AA; inst_ready = 1'b1;
    tick();
    sram_ready = 1'b0;
    tick();
    inst_ready = 1'b0;
    checks++;
    if (fetch_count !== 16'h0000) begin
      errors++;
      $display("FAIL wrap: count=%h want 0000", fetch_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_timeout();
    test_flush();
    test_back_to_back();
    test_stall_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
